keep_sequencer: RTL and testbench

KEEP_SEQUENCER -- requirements
Module: keep_sequencer

---
 rtl/keep_seq_pkg.sv | 14 +
 rtl/len_to_mask.sv | 25 ++
 rtl/keep_sequencer.sv | 128 ++++++++++++
 tb/tb_keep_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/keep_seq_pkg.sv
// rtl/keep_seq_pkg.sv - shared types for the keep sequencer
//
// Purpose: holds the sequencer FSM state encoding so the top and any
//          future helpers agree on it.
// Ports:   none (package).
package keep_seq_pkg;

  // IDLE: waiting for a length command; SEND: presenting beat descriptors.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } seq_state_t;

endpackage

// File: rtl/len_to_mask.sv
// rtl/len_to_mask.sv - byte count to thermometer byte-enable mask
//
// Purpose: turns a byte count (0..LEN_MAX) into a thermometer mask with the
//          LSB first: bit i is set when the count exceeds i.
// Ports:
//   len_i  [LEN_W-1:0]   byte count, expected to be <= LEN_MAX
//   mask_o [LEN_MAX-1:0] thermometer byte-enable
module len_to_mask
  import keep_seq_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int LEN_MAX = 8
) (
  input  logic [LEN_W-1:0]   len_i,
  output logic [LEN_MAX-1:0] mask_o
);

  always_comb begin
    mask_o = '0;
    for (int i = 0; i < LEN_MAX; i++) begin
      mask_o[i] = (int'(len_i) > i);
    end
  end

endmodule

// File: rtl/keep_sequencer.sv
// rtl/keep_sequencer.sv - splits a byte-length command into keep/last beats
//
// Purpose: accepts a packet length in bytes and emits one beat descriptor per
//          KEEP_W-byte beat, with a thermometer keep mask, a last flag and a
//          zero-based beat index. Flush aborts the current packet.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid_i         length command offered
//   cmd_len_i   [LEN_W] packet length in bytes
//   cmd_ready_o         command accepted (high only while idle)
//   flush_i             abort current packet, drop any concurrent command
//   beat_valid_o        beat descriptor presented
//   beat_ready_i        downstream consumes the beat
//   beat_keep_o [KEEP_W] byte-enable, LSB first
//   beat_last_o         final beat of the packet
//   beat_idx_o  [CNT_W] zero-based beat index
module keep_sequencer
  import keep_seq_pkg::*;
#(
  parameter int LEN_W  = 16,
  parameter int KEEP_W = 8,
  parameter int CNT_W  = LEN_W - $clog2(KEEP_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  output logic              cmd_ready_o,
  input  logic              flush_i,
  output logic              beat_valid_o,
  input  logic              beat_ready_i,
  output logic [KEEP_W-1:0] beat_keep_o,
  output logic              beat_last_o,
  output logic [CNT_W-1:0]  beat_idx_o
);

  // Width able to hold the values 0..KEEP_W inclusive.
  localparam int               MASK_LW  = $clog2(KEEP_W) + 1;
  localparam logic [LEN_W-1:0] KEEP_LEN = LEN_W'(KEEP_W);

  seq_state_t         r_state;
  seq_state_t         w_state_nxt;
  logic [LEN_W-1:0]   r_rem;
  logic [LEN_W-1:0]   w_rem_nxt;
  logic [CNT_W-1:0]   r_idx;
  logic [CNT_W-1:0]   w_idx_nxt;
  logic               w_last;
  logic [MASK_LW-1:0] w_rem_min;
  logic [KEEP_W-1:0]  w_mask;

  // The remaining count fits in one beat; it then also fits in MASK_LW bits,
  // so the narrow slice below is exact whenever it is selected.
  assign w_last    = (r_rem <= KEEP_LEN);
  assign w_rem_min = w_last ? r_rem[MASK_LW-1:0] : MASK_LW'(KEEP_W);

  len_to_mask #(
    .LEN_W  (MASK_LW),
    .LEN_MAX(KEEP_W)
  ) u_len_to_mask (
    .len_i (w_rem_min),
    .mask_o(w_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_rem;
    w_idx_nxt    = r_idx;
    cmd_ready_o  = (r_state == IDLE);
    beat_valid_o = (r_state == SEND);
    beat_keep_o  = '0;
    beat_last_o  = 1'b0;
    beat_idx_o   = '0;

    if (r_state == SEND) begin
      beat_keep_o = w_mask;
      beat_last_o = w_last;
      beat_idx_o  = r_idx;
    end

    case (r_state)
      IDLE: begin
        // A zero-length command still handshakes but produces no beats.
        if (cmd_valid_i && (cmd_len_i != '0)) begin
          w_state_nxt = SEND;
          w_rem_nxt   = cmd_len_i;
          w_idx_nxt   = '0;
        end
      end
      SEND: begin
        if (beat_ready_i) begin
          if (w_last) begin
            w_state_nxt = IDLE;
            w_rem_nxt   = '0;
            w_idx_nxt   = '0;
          end else begin
            w_rem_nxt = r_rem - KEEP_LEN;
            w_idx_nxt = r_idx + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_rem_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase

    // Flush overrides any beat or command handshake in the same cycle.
    if (flush_i) begin
      w_state_nxt = IDLE;
      w_rem_nxt   = '0;
      w_idx_nxt   = '0;
    end
  end

endmodule

// File: tb/tb_keep_sequencer.sv
// tb/tb_keep_sequencer.sv - self-checking bench for keep_sequencer
module tb_keep_sequencer;

  localparam int LEN_W  = 16;
  localparam int KEEP_W = 8;
  localparam int CNT_W  = LEN_W - $clog2(KEEP_W) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid_i;
  logic [LEN_W-1:0]  cmd_len_i;
  logic              cmd_ready_o;
  logic              flush_i;
  logic              beat_valid_o;
  logic              beat_ready_i;
  logic [KEEP_W-1:0] beat_keep_o;
  logic              beat_last_o;
  logic [CNT_W-1:0]  beat_idx_o;

  always #5 clk = ~clk;

  keep_sequencer #(
    .LEN_W (LEN_W),
    .KEEP_W(KEEP_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid_i),
    .cmd_len_i   (cmd_len_i),
    .cmd_ready_o (cmd_ready_o),
    .flush_i     (flush_i),
    .beat_valid_o(beat_valid_o),
    .beat_ready_i(beat_ready_i),
    .beat_keep_o (beat_keep_o),
    .beat_last_o (beat_last_o),
    .beat_idx_o  (beat_idx_o)
  );

  typedef struct {
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [CNT_W-1:0]  idx;
  } beat_t;

  // Reference: the beats still owed for the current packet, in order.
  beat_t q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_packet(input int len);
    int n;
    int bytes;
    beat_t b;
    n = (len + KEEP_W - 1) / KEEP_W;
    for (int k = 0; k < n; k++) begin
      bytes  = len - k * KEEP_W;
      if (bytes > KEEP_W) bytes = KEEP_W;
      b.keep = KEEP_W'((1 << bytes) - 1);
      b.last = (k == n - 1);
      b.idx  = CNT_W'(k);
      q.push_back(b);
    end
  endtask

  task automatic check_outputs();
    bit busy;
    busy = (q.size() > 0);
    check("cmd_ready", cmd_ready_o, !busy);
    check("beat_valid", beat_valid_o, busy);
    check("beat_keep", beat_keep_o, busy ? q[0].keep : '0);
    check("beat_last", beat_last_o, busy ? q[0].last : 1'b0);
    check("beat_idx", beat_idx_o, busy ? q[0].idx : '0);
  endtask

  // Called at a falling edge: check current outputs, drive inputs for the
  // next rising edge, advance the reference, then move to the next falling edge.
  task automatic step(input bit cv, input int len, input bit fl, input bit br, input bit r);
    check_outputs();
    cmd_valid_i  = cv;
    cmd_len_i    = LEN_W'(len);
    flush_i      = fl;
    beat_ready_i = br;
    rst          = r;
    if (r || fl) begin
      q.delete();
    end else if (q.size() > 0) begin
      if (br) void'(q.pop_front());
    end else if (cv) begin
      push_packet(len);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, cmd_ready_o, 1'b1);
    check({tag, "_valid"}, beat_valid_o, 1'b0);
    check({tag, "_keep"}, beat_keep_o, '0);
    check({tag, "_last"}, beat_last_o, 1'b0);
    check({tag, "_idx"}, beat_idx_o, '0);
  endtask

  initial begin
    int len;
    int sel;
    rst          = 1'b1;
    cmd_valid_i  = 1'b0;
    cmd_len_i    = '0;
    flush_i      = 1'b0;
    beat_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");

    // len=20, ready always high: FF,FF,0F, last on idx 2.
    step(1, 20, 0, 1, 0);
    check("l20_first_valid", beat_valid_o, 1'b1);
    check("l20_keep0", beat_keep_o, 8'hFF);
    step(0, 0, 0, 1, 0);
    check("l20_keep1", beat_keep_o, 8'hFF);
    check("l20_last1", beat_last_o, 1'b0);
    step(0, 0, 0, 1, 0);
    check("l20_keep2", beat_keep_o, 8'h0F);
    check("l20_last2", beat_last_o, 1'b1);
    check("l20_idx2", beat_idx_o, 2);
    step(0, 0, 0, 1, 0);
    check("l20_done_ready", cmd_ready_o, 1'b1);

    // len=16: FF,FF with last on idx 1; len=1: one beat 01.
    step(1, 16, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check("l16_keep1", beat_keep_o, 8'hFF);
    check("l16_last1", beat_last_o, 1'b1);
    check("l16_idx1", beat_idx_o, 1);
    step(0, 0, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    check("l1_keep", beat_keep_o, 8'h01);
    check("l1_last", beat_last_o, 1'b1);
    step(0, 0, 0, 1, 0);

    // len=0: handshake only.
    check("l0_ready", cmd_ready_o, 1'b1);
    step(1, 0, 0, 1, 0);
    check("l0_valid", beat_valid_o, 1'b0);
    check("l0_ready_after", cmd_ready_o, 1'b1);

    // len=20 with a three-cycle stall on beat 1.
    step(1, 20, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0);
      check("stall_keep", beat_keep_o, 8'hFF);
      check("stall_idx", beat_idx_o, 1);
      check("stall_valid", beat_valid_o, 1'b1);
    end
    repeat (3) step(0, 0, 0, 1, 0);

    // Flush on beat 1 of len=24, then len=3.
    step(1, 24, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 9, 1, 1, 0);
    check("flush_valid", beat_valid_o, 1'b0);
    check("flush_ready", cmd_ready_o, 1'b1);
    step(1, 3, 0, 1, 0);
    check("l3_keep", beat_keep_o, 8'h07);
    check("l3_idx", beat_idx_o, 0);
    check("l3_last", beat_last_o, 1'b1);
    step(0, 0, 0, 1, 0);

    // Command together with flush while idle is dropped.
    step(1, 5, 1, 1, 0);
    check("flush_cmd_drop", beat_valid_o, 1'b0);

    // Reset mid-packet, then reset together with flush.
    step(1, 40, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    check_reset_values("rst_mid");
    step(1, 40, 0, 1, 0);
    step(0, 0, 1, 1, 1);
    check_reset_values("rst_flush");

    // Maximum length: 8192 beats, last beat holds 7 bytes.
    step(1, (1 << LEN_W) - 1, 0, 1, 0);
    repeat (8191) step(0, 0, 0, 1, 0);
    check("max_idx", beat_idx_o, 8191);
    check("max_keep", beat_keep_o, 8'h7F);
    check("max_last", beat_last_o, 1'b1);
    step(0, 0, 0, 1, 0);
    check("max_done_ready", cmd_ready_o, 1'b1);

    // Randomized traffic against the reference.
    for (int c = 0; c < 4000; c++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)     len = 0;
      else if (sel < 8) len = $urandom_range(1, 40);
      else              len = $urandom_range(41, 400);
      step($urandom_range(0, 1), len,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 299) == 0);
    end
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
